// File: rtl/seq_detector_multi_pkg.sv
// Shared types and constants for the multi-pattern serial detector.
package seq_det_pkg;

  // Detector state: FILL while the history still holds stale or too few bits,
  // ARMED once every qualified bit completes a full comparison window.
  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } detState_e;

  // Encodings of the overlap input.
  localparam logic MODE_NONOVERLAP = 1'b0;
  localparam logic MODE_OVERLAP    = 1'b1;

  localparam int DEFAULT_NUM_PAT = 4;

  // Width of a slot index; a single slot still gets a one-bit index port.
  function automatic int idx_width(input int numPat);
    return (numPat > 1) ? $clog2(numPat) : 1;
  endfunction

  localparam int DEFAULT_IDX_W = idx_width(DEFAULT_NUM_PAT);

endpackage

// File: rtl/seq_detector_multi_sat_counter.sv
// Saturating event counter with a sticky saturation flag.
// A clear beats a simultaneous increment and also drops the sticky flag.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             sat_q;
  logic             sat_d;

  // Next count: clear first, otherwise step until all-ones and latch the flag there.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr_i) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      if (inc_i && (count_q != CNT_MAX)) begin
        count_d = count_q + CNT_W'(1);
      end
      if (count_d == CNT_MAX) begin
        sat_d = 1'b1;
      end
    end
  end

  // Counter and flag registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/seq_detector_multi.sv
// Multi-pattern serial sequence detector.
// Shifts qualified serial bits into a short history and compares the newest
// PAT_W-bit window against NUM_PAT programmable, individually enabled slots.
module seq_detector_multi
  import seq_det_pkg::*;
#(
  parameter int PAT_W   = 4,
  parameter int NUM_PAT = 4,
  parameter int CNT_W   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             x,
  input  logic                             x_valid,
  input  logic                             cfg_we,
  input  logic [idx_width(NUM_PAT)-1:0]    cfg_idx,
  input  logic [PAT_W-1:0]                 cfg_pattern,
  input  logic [NUM_PAT-1:0]               cfg_en_mask,
  input  logic                             overlap,
  input  logic                             count_clr,
  output logic                             z,
  output logic [NUM_PAT-1:0]               match_vec,
  output logic [CNT_W-1:0]                 match_count,
  output logic                             count_sat
);

  localparam int IDX_W  = idx_width(NUM_PAT);
  localparam int FILL_W = $clog2(PAT_W + 1);

  // Only the PAT_W-1 most recent bits are stored; the incoming bit completes the window.
  logic [PAT_W-2:0]   hist_q;
  logic [PAT_W-2:0]   hist_d;
  logic [FILL_W-1:0]  fillCnt_q;
  logic [FILL_W-1:0]  fillCnt_d;
  detState_e          state_q;
  detState_e          state_d;
  logic               z_q;
  logic [NUM_PAT-1:0] matchVec_q;

  logic [PAT_W-1:0]   window;
  logic               windowValid;
  logic               cmpEnable;
  logic [NUM_PAT-1:0] hitVec;
  logic               anyHit;

  assign window      = {hist_q, x};
  assign windowValid = (state_q == ARMED) ||
                       ((state_q == FILL) && (fillCnt_q == FILL_W'(PAT_W - 1)));
  assign cmpEnable   = x_valid & windowValid;
  assign anyHit      = |hitVec;

  // One storage register and one comparator per slot. The compare uses the
  // stored value, so a write on the same edge only affects later bits.
  for (genvar i = 0; i < NUM_PAT; i++) begin : gSlot
    logic [PAT_W-1:0] pattern_q;

    // Capture a new pattern when this slot is addressed by a config write.
    always_ff @(posedge clk) begin
      if (reset) begin
        pattern_q <= '0;
      end else if (cfg_we && (cfg_idx == IDX_W'(i))) begin
        pattern_q <= cfg_pattern;
      end
    end

    assign hitVec[i] = cmpEnable & cfg_en_mask[i] & (window == pattern_q);
  end

  // Next-state logic: shift on qualified bits, count fill progress, and in
  // non-overlap mode drop back to FILL after a hit so the next match needs fresh bits.
  always_comb begin
    state_d   = state_q;
    fillCnt_d = fillCnt_q;
    hist_d    = hist_q;
    if (x_valid) begin
      hist_d = window[PAT_W-2:0];
      if (anyHit && (overlap == MODE_NONOVERLAP)) begin
        state_d   = FILL;
        fillCnt_d = '0;
      end else if (state_q == FILL) begin
        if (fillCnt_q == FILL_W'(PAT_W - 1)) begin
          state_d   = ARMED;
          fillCnt_d = FILL_W'(PAT_W);
        end else begin
          fillCnt_d = fillCnt_q + FILL_W'(1);
        end
      end
    end
  end

  // State, fill counter and history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FILL;
      fillCnt_q <= '0;
      hist_q    <= '0;
    end else begin
      state_q   <= state_d;
      fillCnt_q <= fillCnt_d;
      hist_q    <= hist_d;
    end
  end

  // Registered match outputs: one-cycle pulses following the completing bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      z_q        <= 1'b0;
      matchVec_q <= '0;
    end else begin
      z_q        <= anyHit;
      matchVec_q <= hitVec;
    end
  end

  // Counts match cycles, so several slots hitting together add only one.
  sat_counter #(
    .CNT_W (CNT_W)
  ) uMatchCounter (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (anyHit),
    .clr_i   (count_clr),
    .count_o (match_count),
    .sat_o   (count_sat)
  );

  assign z         = z_q;
  assign match_vec = matchVec_q;

endmodule
